// File: rtl/snn_q14_pkg.sv
// Shared Q1.14 helpers for the synaptic weight memory (learner and inference reader).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: Q fraction width, 16-bit signed weight type, weight address map
// (addr = f*N + n), a width-parameterised saturating add and the accumulator FSM states.
package snn_q14_pkg;

  localparam int Q = 14;

  typedef logic signed [15:0] w_q14_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_READ,
    ST_DRAIN,
    ST_STREAM
  } acc_state_e;

  // Row-major weight layout: one row of n_cnt weights per presynapse.
  function automatic int unsigned fn_addr(input int unsigned f,
                                          input int unsigned n,
                                          input int unsigned n_cnt);
    return f * n_cnt + n;
  endfunction

  // Signed add clamped to a w-bit two's complement range.
  // Operands arrive sign-extended to 64 bits, so the raw sum cannot wrap
  // for any practical w. The caller truncates the result back to w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/synapse_accum_q14.sv
// Scans a latched pre-spike vector, sums active weight rows into N saturating currents, streams them out.
// Latency: start to first out_valid = 1 + F + K*N + 1 cycles (K = active presynapses) with out_ready high.
// Backpressure: out_valid/out_ready; the output register holds while stalled, no upstream stall on memory.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, pre_bits         timestep start pulse and pre-spike vector (sampled only on accepted start)
//   busy, done              busy from start until after last handshake; done pulses the cycle after it
//   mem_re, mem_addr        weight read request, addr = f*N + n
//   mem_rdata               signed Q1.14 weight, one cycle after mem_re
//   out_valid, out_ready    current stream handshake
//   out_idx, out_data       neuron index and signed saturated current
//   out_last                marks out_idx == N-1
module synapse_accum_q14
  import snn_q14_pkg::acc_state_e, snn_q14_pkg::ST_IDLE, snn_q14_pkg::ST_SCAN,
         snn_q14_pkg::ST_READ, snn_q14_pkg::ST_DRAIN, snn_q14_pkg::ST_STREAM,
         snn_q14_pkg::fn_addr, snn_q14_pkg::sat_add;
#(
  parameter  int F     = 48,
  parameter  int N     = 96,
  parameter  int Q     = 14,
  parameter  int ACC_W = 24,
  localparam int AW    = (F * N > 1) ? $clog2(F * N) : 1,
  localparam int FW    = (F > 1) ? $clog2(F) : 1,
  localparam int NW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [F-1:0]            pre_bits,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_re,
  output logic [AW-1:0]           mem_addr,
  input  logic signed [Q+1:0]     mem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NW-1:0]           out_idx,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_last
);

  acc_state_e             state_q, state_d;
  logic [F-1:0]           pre_q, pre_d;
  logic [FW-1:0]          f_q, f_d;
  logic [NW-1:0]          n_q, n_d;
  // Read-return tracking: the weight for neuron rd_n_q is on mem_rdata
  // in the cycle rd_pend_q is high.
  logic                   rd_pend_q, rd_pend_d;
  logic [NW-1:0]          rd_n_q, rd_n_d;
  logic signed [ACC_W-1:0] acc_q [N];
  logic signed [ACC_W-1:0] acc_d [N];
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   mem_re_q, mem_re_d;
  logic [AW-1:0]          mem_addr_q, mem_addr_d;
  logic                   out_valid_q, out_valid_d;
  logic [NW-1:0]          out_idx_q, out_idx_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    f_d         = f_q;
    n_d         = n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    acc_d       = acc_q;

    // Accumulate stage runs independently of the scan, so the returning
    // data of one row overlaps the SCAN bubble / DRAIN that follows it.
    if (rd_pend_q) begin
      acc_d[rd_n_q] = ACC_W'(sat_add(64'(acc_q[rd_n_q]), 64'(mem_rdata), ACC_W));
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pre_d   = pre_bits;
          f_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
          for (int i = 0; i < N; i++) acc_d[i] = '0;
        end
      end
      ST_SCAN: begin
        if (pre_q[f_q]) begin
          n_d     = '0;
          state_d = ST_READ;
        end else if (f_q == FW'(F - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          f_d = f_q + FW'(1);
        end
      end
      ST_READ: begin
        if (n_q == NW'(N - 1)) begin
          if (f_q == FW'(F - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            f_d     = f_q + FW'(1);
            state_d = ST_SCAN;
          end
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      ST_DRAIN: begin
        // acc_d already holds the final read, so the first sample is exact.
        state_d     = ST_STREAM;
        out_valid_d = 1'b1;
        out_idx_d   = '0;
        out_data_d  = acc_d[0];
        out_last_d  = (N == 1);
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
          end else begin
            out_idx_d  = out_idx_q + NW'(1);
            out_data_d = acc_q[out_idx_q + NW'(1)];
            out_last_d = ((out_idx_q + NW'(1)) == NW'(N - 1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Read port is registered: issue for the (f, n) the FSM is entering.
    mem_re_d   = (state_d == ST_READ);
    mem_addr_d = mem_re_d ? AW'(fn_addr(32'(f_d), 32'(n_d), N)) : mem_addr_q;
    rd_pend_d  = mem_re_q;
    rd_n_d     = n_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      f_q         <= '0;
      n_q         <= '0;
      rd_pend_q   <= 1'b0;
      rd_n_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < N; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      f_q         <= f_d;
      n_q         <= n_d;
      rd_pend_q   <= rd_pend_d;
      rd_n_q      <= rd_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      acc_q       <= acc_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_synapse_accum_q14.sv
// Directed bench for synapse_accum_q14 with F=4, N=3.
// Instance a: ACC_W=24, memory w[f][n] = (f+1)*100 + n.
// Instance b: ACC_W=16, every weight equal to wb_val (saturation cases).
module tb_synapse_accum_q14;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic              start_a, busy_a, done_a, mem_re_a;
  logic [3:0]        pre_a, mem_addr_a;
  logic signed [15:0] rdata_a = '0;
  logic              out_valid_a, out_ready_a, out_last_a;
  logic [1:0]        out_idx_a;
  logic signed [23:0] out_data_a;

  logic              start_b, busy_b, done_b, mem_re_b;
  logic [3:0]        pre_b, mem_addr_b;
  logic signed [15:0] rdata_b = '0;
  logic              out_valid_b, out_last_b;
  logic [1:0]        out_idx_b;
  logic signed [15:0] out_data_b;
  logic signed [15:0] wb_val;

  logic signed [15:0] w_a [12];

  synapse_accum_q14 #(.F(4), .N(3), .ACC_W(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pre_bits(pre_a),
    .busy(busy_a), .done(done_a), .mem_re(mem_re_a), .mem_addr(mem_addr_a),
    .mem_rdata(rdata_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_idx(out_idx_a), .out_data(out_data_a), .out_last(out_last_a)
  );

  synapse_accum_q14 #(.F(4), .N(3), .ACC_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pre_bits(pre_b),
    .busy(busy_b), .done(done_b), .mem_re(mem_re_b), .mem_addr(mem_addr_b),
    .mem_rdata(rdata_b), .out_valid(out_valid_b), .out_ready(1'b1),
    .out_idx(out_idx_b), .out_data(out_data_b), .out_last(out_last_b)
  );

  // Synchronous-read weight memories.
  always @(posedge clk) if (mem_re_a) rdata_a <= w_a[mem_addr_a];
  always @(posedge clk) if (mem_re_b) rdata_b <= wb_val;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Per-run capture for instance a.
  logic signed [63:0] got_d [3];
  int got_i [3];
  int got_l [3];
  int got_n, re_cnt, done_cnt, first_vld, hold_err, busy_at_done;

  // bp: out_ready follows 1,0,0 repeating. inj: second start (pre 1000) on the first READ cycle.
  task automatic run_a(input logic [3:0] pre, input bit bp, input bit inj);
    int injd;
    int done_cyc;
    bit stall;
    logic signed [63:0] hd;
    int hi;
    got_n = 0; re_cnt = 0; done_cnt = 0; first_vld = -1; hold_err = 0;
    busy_at_done = -1; injd = 0; done_cyc = -1; stall = 1'b0; hd = 0; hi = 0;
    for (int k = 0; k < 3; k++) begin
      got_d[k] = 'x; got_i[k] = -1; got_l[k] = -1;
    end
    @(negedge clk); pre_a = pre; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0; pre_a = ~pre;
    for (int cyc = 1; cyc < 300; cyc++) begin
      out_ready_a = bp ? ((cyc % 3) == 0) : 1'b1;
      if (injd == 1) begin start_a = 1'b0; injd = 2; end
      if (mem_re_a) re_cnt++;
      if (inj && injd == 0 && mem_re_a) begin
        start_a = 1'b1; pre_a = 4'b1000; injd = 1;
      end
      if (out_valid_a) begin
        if (first_vld < 0) first_vld = cyc;
        if (stall && (out_data_a !== hd || int'(out_idx_a) != hi)) hold_err++;
        if (out_ready_a) begin
          if (got_n < 3) begin
            got_d[got_n] = out_data_a;
            got_i[got_n] = int'(out_idx_a);
            got_l[got_n] = int'(out_last_a);
          end
          got_n++;
          stall = 1'b0;
        end else begin
          stall = 1'b1; hd = out_data_a; hi = int'(out_idx_a);
        end
      end
      if (done_a) begin
        done_cnt++;
        busy_at_done = int'(busy_a);
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    out_ready_a = 1'b1;
    start_a = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int e0, input int e1, input int e2);
    int ev [3];
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    chk({tag, "_count"}, got_n, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_data%0d", tag, k), got_d[k], ev[k]);
      chk($sformatf("%s_idx%0d", tag, k), got_i[k], k);
      chk($sformatf("%s_last%0d", tag, k), got_l[k], (k == 2) ? 1 : 0);
    end
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  task automatic run_b(input logic signed [15:0] w, input logic signed [63:0] expv);
    int n;
    int dc;
    wb_val = w; n = 0; dc = 0;
    @(negedge clk); pre_b = 4'b1111; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int cyc = 1; cyc < 300 && dc == 0; cyc++) begin
      if (out_valid_b) begin
        chk($sformatf("sat_w%0d_idx%0d", w, n), out_data_b, expv);
        n++;
      end
      if (done_b) dc++;
      @(negedge clk);
    end
    chk($sformatf("sat_w%0d_count", w), n, 3);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_mem_re"}, mem_re_a, 0);
    chk({tag, "_mem_addr"}, mem_addr_a, 0);
    chk({tag, "_out_valid"}, out_valid_a, 0);
    chk({tag, "_out_idx"}, out_idx_a, 0);
    chk({tag, "_out_data"}, out_data_a, 0);
    chk({tag, "_out_last"}, out_last_a, 0);
  endtask

  initial begin
    int wait_cyc;
    rst_n = 1'b0;
    start_a = 1'b0; pre_a = '0; out_ready_a = 1'b1;
    start_b = 1'b0; pre_b = '0; wb_val = '0;
    for (int f = 0; f < 4; f++)
      for (int n = 0; n < 3; n++)
        w_a[f * 3 + n] = 16'((f + 1) * 100 + n);

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    chk("reset_b_busy", busy_b, 0);
    chk("reset_b_out_valid", out_valid_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // f0 + f2 rows: (100+n) + (300+n).
    run_a(4'b0101, 1'b0, 1'b0);
    check_stream("basic", 400, 402, 404);
    chk("basic_mem_re_cnt", re_cnt, 6);
    chk("basic_latency", first_vld, 12);

    run_a(4'b0000, 1'b0, 1'b0);
    check_stream("zero", 0, 0, 0);
    chk("zero_mem_re_cnt", re_cnt, 0);
    chk("zero_latency", first_vld, 6);

    run_a(4'b1111, 1'b1, 1'b0);
    check_stream("bp", 1000, 1004, 1008);
    chk("bp_hold_stable", hold_err, 0);
    chk("bp_mem_re_cnt", re_cnt, 12);

    run_b(16'sd16384, 32767);
    run_b(-16'sd16384, -32768);

    run_a(4'b0101, 1'b0, 1'b1);
    check_stream("busy_start", 400, 402, 404);
    chk("busy_start_mem_re_cnt", re_cnt, 6);
    chk("busy_start_latency", first_vld, 12);

    // Abort in READ, then a clean run must not see stale sums.
    @(negedge clk); pre_a = 4'b1111; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_cyc = 0;
    while (!mem_re_a && wait_cyc < 20) begin
      @(negedge clk); wait_cyc++;
    end
    chk("rst_reached_read", mem_re_a, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    run_a(4'b0010, 1'b0, 1'b0);
    check_stream("post_rst", 200, 201, 202);
    chk("post_rst_mem_re_cnt", re_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/synapse_accum_q14.md
Name: synapse_accum_q14

Overview:
- Inference-side reader of the Q1.14 weight memory that the STDP learner writes; address layout is identical (addr = f*N + n).
- On each timestep start it latches the pre-spike vector and scans it. For every active presynapse f it reads row f, one weight per clock, and accumulates into N signed per-neuron input currents.
- It then streams the N currents out over a valid/ready interface to the neuron update stage.

Parameters:
- F, 48, number of presynaptic inputs
- N, 96, number of postsynaptic neurons
- Q, 14, fractional bits of weights and currents (informational; no rescaling is performed)
- ACC_W, 24, accumulator and output width in bits, signed, saturating
- AW, $clog2(F*N), localparam, weight address width
- FW/NW, localparams, max(1,$clog2(F)) and max(1,$clog2(N))

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begin timestep; ignored while busy=1
- pre_bits  in  F  pre-spike vector, sampled only on accepted start
- busy  out  1  high from accepted start until the cycle after final stream handshake
- done  out  1  one-cycle pulse in the cycle after the last out handshake
- mem_re  out  1  weight read enable
- mem_addr  out  AW  weight address f*N+n
- mem_rdata  in  16  signed Q14 weight, valid exactly 1 cycle after mem_re (synchronous read)
- out_valid  out  1  current sample valid
- out_ready  in  1  downstream accept
- out_idx  out  NW  neuron index of out_data
- out_data  out  ACC_W  signed accumulated current, Q14
- out_last  out  1  high with out_idx==N-1

Behaviour:
- Reset: every output is 0, acc[] cleared, state IDLE. Reset mid-operation aborts the scan and streaming immediately with no done pulse; a new start is required.
- FSM states: IDLE, SCAN, READ, DRAIN, STREAM.
- IDLE: start=1 latches pre_bits into pre_q, clears all acc[n] to 0, sets f=0, busy=1, and moves to SCAN.
- SCAN: one f per clock. If pre_q[f]=1, go to READ with n=0. Otherwise, if f==F-1 go to DRAIN, else f++.
- READ: mem_re=1, mem_addr=f*N+n each clock, n++. At n==N-1, if f==F-1 go to DRAIN, else f++ and go to SCAN. The row read is contiguous with no bubbles; a one-cycle SCAN bubble occurs between rows.
- Accumulate pipeline: re_d<=mem_re and n_d<=n. When re_d=1, acc[n_d] <= sat(acc[n_d] + sext(mem_rdata)).
- sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A saturated acc stays clamped and subsequent adds re-saturate.
- DRAIN: one cycle so the last read's data is accumulated. Then go to STREAM with idx=0.
- STREAM: out_valid=1, out_idx=idx, out_data=acc[idx], out_last=(idx==N-1).
  - Outputs hold stable while out_valid && !out_ready.
  - On a handshake, idx++.
  - On the handshake with out_last, go to IDLE, busy drops, and done pulses the next cycle.
- All-zero pre_bits: F SCAN cycles, no mem_re, then N zeros streamed.
- Latency (out_ready tied to 1): start to first out_valid = 1 + F + K*N + 1 cycles, K = popcount(pre_bits).
- start while busy has no effect. pre_bits changes after start have no effect.
- mem_re is 0 outside READ. mem_addr holds its last value when idle.

Decomposition:
- Shared package snn_q14_pkg holds:
  - Q=14 localparam
  - typedef logic signed [15:0] w_q14_t
  - fn_addr(f,n) function
  - sat_add function, parameterized by ACC_W via a width argument
- The STDP learner uses the same package.
- No sub-module: FSM, accumulator array and stream register live in one module.

Test Plan:
- Test parameters are F=4, N=3, ACC_W=24, with the weight memory model loaded as w[f][n]=(f+1)*100+n.
- Basic case: pre_bits=4'b0101, out_ready=1 -> stream 400,402,404. out_last only on idx 2. done pulses once. mem_re count=6.
- All-zero case: pre_bits=0 -> stream 0,0,0. mem_re is never asserted. First out_valid arrives 6 cycles after start.
- Backpressure: pre_bits=4'b1111 with out_ready toggled 1,0,0,1,... -> values 1000,1004,1008 are each held stable while stalled, with no duplicates and no drops.
- Saturation: ACC_W=16, all weights +16384, pre_bits=4'b1111 -> every out_data is 32767.
  - Same with weights -16384 -> every out_data is -32768.
- Start during busy: a second start pulse with pre_bits=4'b1000 during READ is ignored and results match the first pre_bits.
- Reset mid-run: assert rst_n=0 in READ -> all outputs 0 next cycle. After release, a start with pre_bits=4'b0010 streams 200,201,202 with no stale accumulation.
